// File: rtl/fetcher_if.sv
// Instruction-memory read port of the fetch stage: request/grant address phase
// followed by an rvalid data phase. One outstanding transaction at a time.
interface fetcher_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_gnt,
        input  mem_rvalid,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_gnt,
        output mem_rvalid,
        output mem_rdata
    );
endinterface

// File: rtl/fetcher.sv
// Instruction-fetch stage: holds the PC, issues one read per fetch_start over the
// req/gnt/rvalid port and registers the returned word for the decoder.
// A redirect (pc_we) during an in-flight fetch turns the returning data stale:
// it is drained and the word at the redirected PC is fetched instead.
// Optional build macro FETCHER_MISALIGN_EN: misaligned fetches are not issued to
// memory; they complete at once with NOP_INSTR and raise fetch_err.
module fetcher #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_start,
    input  logic        pc_we,
    input  logic [31:0] pc_next,
    fetcher_if.master   mem,
    output logic [31:0] instr_raw,
    output logic [31:0] instr_pc,
    output logic [31:0] pc,
    output logic        busy,
`ifdef FETCHER_MISALIGN_EN
    output logic        fetch_err,
`endif
    output logic        fetch_done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t      state_r, state_s;
    logic [31:0] pc_r, pc_s;
    logic [31:0] target_s;
    logic        mem_req_r, mem_req_s;
    logic [31:0] mem_addr_r, mem_addr_s;
    logic [31:0] instr_raw_r, instr_raw_s;
    logic [31:0] instr_pc_r, instr_pc_s;
    logic        fetch_done_r, fetch_done_s;
    logic        busy_r, busy_s;
    // set when a redirect lands while the request is still waiting for grant
    logic        flush_r, flush_s;
`ifdef FETCHER_MISALIGN_EN
    logic        err_r, err_s;
`endif

    assign busy_s = (state_s != ST_IDLE);

    // Next-state and next-output logic for the fetch FSM
    always_comb begin
        state_s      = state_r;
        pc_s         = pc_r;
        target_s     = pc_r;
        mem_req_s    = mem_req_r;
        mem_addr_s   = mem_addr_r;
        instr_raw_s  = instr_raw_r;
        instr_pc_s   = instr_pc_r;
        fetch_done_s = 1'b0;
        flush_s      = flush_r;
`ifdef FETCHER_MISALIGN_EN
        err_s        = err_r;
`endif
        // a redirect always updates pc; same-cycle issue uses the new target
        if (pc_we) begin
            pc_s     = pc_next;
            target_s = pc_next;
`ifdef FETCHER_MISALIGN_EN
            err_s    = 1'b0;
`endif
        end else begin
            pc_s     = pc_r;
            target_s = pc_r;
        end
        case (state_r)
            ST_IDLE: begin
                if (fetch_start) begin
`ifdef FETCHER_MISALIGN_EN
                    if (target_s[1:0] != 2'b00) begin
                        instr_raw_s  = NOP_INSTR;
                        instr_pc_s   = target_s;
                        fetch_done_s = 1'b1;
                        err_s        = 1'b1;
                    end else begin
                        state_s    = ST_REQ;
                        mem_req_s  = 1'b1;
                        mem_addr_s = target_s;
                        flush_s    = 1'b0;
                    end
`else
                    state_s    = ST_REQ;
                    mem_req_s  = 1'b1;
                    mem_addr_s = target_s;
                    flush_s    = 1'b0;
`endif
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (mem.mem_gnt) begin
                    mem_req_s = 1'b0;
                    flush_s   = 1'b0;
                    if (flush_r || pc_we) begin
                        state_s = ST_DRAIN;
                    end else begin
                        state_s = ST_WAIT;
                    end
                end else if (pc_we) begin
                    flush_s = 1'b1;
                end else begin
                    state_s = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (mem.mem_rvalid) begin
                    instr_raw_s  = mem.mem_rdata;
                    instr_pc_s   = mem_addr_r;
                    fetch_done_s = 1'b1;
                    state_s      = ST_IDLE;
`ifdef FETCHER_MISALIGN_EN
                    err_s        = 1'b0;
`endif
                end else if (pc_we) begin
                    state_s = ST_DRAIN;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_DRAIN: begin
                if (mem.mem_rvalid) begin
                    state_s    = ST_REQ;
                    mem_req_s  = 1'b1;
                    mem_addr_s = target_s;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            default: begin
                state_s   = ST_IDLE;
                mem_req_s = 1'b0;
                flush_s   = 1'b0;
            end
        endcase
    end

    // State register and registered outputs, cleared asynchronously by rst
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            pc_r         <= RESET_PC;
            mem_req_r    <= 1'b0;
            mem_addr_r   <= RESET_PC;
            instr_raw_r  <= NOP_INSTR;
            instr_pc_r   <= RESET_PC;
            fetch_done_r <= 1'b0;
            busy_r       <= 1'b0;
            flush_r      <= 1'b0;
`ifdef FETCHER_MISALIGN_EN
            err_r        <= 1'b0;
`endif
        end else begin
            state_r      <= state_s;
            pc_r         <= pc_s;
            mem_req_r    <= mem_req_s;
            mem_addr_r   <= mem_addr_s;
            instr_raw_r  <= instr_raw_s;
            instr_pc_r   <= instr_pc_s;
            fetch_done_r <= fetch_done_s;
            busy_r       <= busy_s;
            flush_r      <= flush_s;
`ifdef FETCHER_MISALIGN_EN
            err_r        <= err_s;
`endif
        end
    end

    assign mem.mem_req  = mem_req_r;
    assign mem.mem_addr = mem_addr_r;
    assign instr_raw    = instr_raw_r;
    assign instr_pc     = instr_pc_r;
    assign pc           = pc_r;
    assign busy         = busy_r;
    assign fetch_done   = fetch_done_r;
`ifdef FETCHER_MISALIGN_EN
    assign fetch_err    = err_r;
`endif

endmodule

// File: tb/tb_fetcher.sv
// Randomized bench for fetcher. Stimulus tasks play both the core controller and
// the instruction memory, and push the expected memory requests and completed
// fetches into queues; a monitor on the falling edge pops and compares.
module tb_fetcher;
    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_start;
    logic        pc_we;
    logic [31:0] pc_next;
    logic [31:0] instr_raw;
    logic [31:0] instr_pc;
    logic [31:0] pc;
    logic        busy;
    logic        fetch_done;
`ifdef FETCHER_MISALIGN_EN
    logic        fetch_err;
`endif

    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [31:0] STALE = 32'hDEAD_BEEF;

    fetcher_if mem_if();

    fetcher dut (
        .clk        (clk),
        .rst        (rst),
        .fetch_start(fetch_start),
        .pc_we      (pc_we),
        .pc_next    (pc_next),
        .mem        (mem_if),
        .instr_raw  (instr_raw),
        .instr_pc   (instr_pc),
        .pc         (pc),
        .busy       (busy),
`ifdef FETCHER_MISALIGN_EN
        .fetch_err  (fetch_err),
`endif
        .fetch_done (fetch_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] ipc;
        logic [31:0] raw;
        logic [31:0] pcv;
        logic        err;
    } done_t;

    done_t       exp_done[$];
    logic [31:0] exp_req[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_pc;

    // instruction memory contents
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: mem_word = 32'h0050_0093;
            32'h0000_0080: mem_word = 32'h0000_0463;
            default:       mem_word = (a * 32'h9E37_79B1) ^ 32'h0000_0013;
        endcase
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [31:0] r;
        r = $urandom;
        r[1:0] = 2'b00;
        rand_addr = r;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic push_done(input logic [31:0] ipc, input logic [31:0] raw,
                             input logic [31:0] pcv, input logic err);
        done_t e;
        e.ipc = ipc;
        e.raw = raw;
        e.pcv = pcv;
        e.err = err;
        exp_done.push_back(e);
    endtask

    // scoreboard monitor: memory requests and completed fetches
    always @(negedge clk) begin
        done_t       e;
        logic [31:0] a;
        if (!rst) begin
            if (mem_if.mem_req) begin
                if (exp_req.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL req_unexpected actual mem_addr=%h required no request", mem_if.mem_addr);
                end else begin
                    check32("mem_addr", mem_if.mem_addr, exp_req[0]);
                    if (mem_if.mem_gnt) a = exp_req.pop_front();
                end
            end
            if (fetch_done) begin
                if (exp_done.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL done_unexpected actual instr_pc=%h required no fetch_done", instr_pc);
                end else begin
                    e = exp_done.pop_front();
                    check32("instr_pc", instr_pc, e.ipc);
                    check32("instr_raw", instr_raw, e.raw);
                    check32("pc_at_done", pc, e.pcv);
                    check32("busy_at_done", {31'd0, busy}, 32'd0);
`ifdef FETCHER_MISALIGN_EN
                    check32("fetch_err", {31'd0, fetch_err}, {31'd0, e.err});
`endif
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        fetch_start       = 1'b0;
        pc_we             = 1'b0;
        mem_if.mem_gnt    = 1'b0;
        mem_if.mem_rvalid = 1'b0;
    endtask

    task automatic redirect(input logic [31:0] t);
        pc_we    = 1'b1;
        pc_next  = t;
        model_pc = t;
    endtask

    // ignored traffic: fetch_start while busy, rvalid outside the data phase
    task automatic noise(input bit rv);
        fetch_start = ($urandom_range(0, 3) == 0);
        if (rv && ($urandom_range(0, 3) == 0)) begin
            mem_if.mem_rvalid = 1'b1;
            mem_if.mem_rdata  = 32'hBAD0_0000 | $urandom_range(0, 255);
        end
    endtask

    // address phase: gd cycles without grant, then grant; redirect in cycle rr
    task automatic req_phase(input int gd, input int rr, input logic [31:0] t);
        for (int i = 0; i <= gd; i++) begin
            noise(1'b1);
            mem_if.mem_gnt = (i == gd);
            if (i == rr) redirect(t);
            tick();
            drive_idle();
        end
    endtask

    // data phase: rd cycles without rvalid, then rvalid with d; redirects at r1/r2
    task automatic rsp_phase(input int rd, input logic [31:0] d, input int r1,
                             input logic [31:0] t1, input int r2, input logic [31:0] t2);
        for (int i = 0; i <= rd; i++) begin
            noise(1'b0);
            if (i == rd) begin
                mem_if.mem_rvalid = 1'b1;
                mem_if.mem_rdata  = d;
            end
            if (i == r1) redirect(t1);
            if (i == r2) redirect(t2);
            tick();
            drive_idle();
        end
    endtask

    // one fetch; mode 0 plain, 1 redirect in REQ, 2 in WAIT, 3 with rvalid,
    // 4 in WAIT and again in DRAIN. set_mode: 0 keep pc, 1 pc_we first, 2 same cycle
    task automatic run_fetch(input logic [31:0] a, input int set_mode, input int mode,
                             input logic [31:0] b, input logic [31:0] c,
                             input int gd_in, input int rd_in);
        int          gd, rd, r1, r2;
        logic [31:0] start_pc, fin;
        gd = (gd_in < 0) ? int'($urandom_range(0, 3)) : gd_in;
        rd = (rd_in < 0) ? int'($urandom_range(0, 3)) : rd_in;
        fin = b;
        if (set_mode == 1) begin
            redirect(a);
            tick();
            drive_idle();
        end
        fetch_start = 1'b1;
        if (set_mode == 2) redirect(a);
        start_pc = model_pc;
        exp_req.push_back(start_pc);
        tick();
        drive_idle();
        case (mode)
            0: begin
                push_done(start_pc, mem_word(start_pc), start_pc, 1'b0);
                req_phase(gd, -1, 32'd0);
                rsp_phase(rd, mem_word(start_pc), -1, 32'd0, -1, 32'd0);
            end
            3: begin
                push_done(start_pc, mem_word(start_pc), b, 1'b0);
                req_phase(gd, -1, 32'd0);
                rsp_phase(rd, mem_word(start_pc), rd, b, -1, 32'd0);
            end
            1: begin
                req_phase(gd, int'($urandom_range(0, gd)), b);
                fin = b;
                exp_req.push_back(fin);
                push_done(fin, mem_word(fin), fin, 1'b0);
                rsp_phase(rd, STALE, -1, 32'd0, -1, 32'd0);
            end
            2: begin
                rd = int'($urandom_range(1, 4));
                r1 = int'($urandom_range(0, rd - 1));
                req_phase(gd, -1, 32'd0);
                fin = b;
                exp_req.push_back(fin);
                push_done(fin, mem_word(fin), fin, 1'b0);
                rsp_phase(rd, STALE, r1, b, -1, 32'd0);
            end
            default: begin
                rd = int'($urandom_range(2, 5));
                r1 = int'($urandom_range(0, rd - 2));
                r2 = int'($urandom_range(r1 + 1, rd - 1));
                req_phase(gd, -1, 32'd0);
                fin = c;
                exp_req.push_back(fin);
                push_done(fin, mem_word(fin), fin, 1'b0);
                rsp_phase(rd, STALE, r1, b, r2, c);
            end
        endcase
        if (mode == 1 || mode == 2 || mode == 4) begin
            req_phase(int'($urandom_range(0, 3)), -1, 32'd0);
            rsp_phase(int'($urandom_range(0, 3)), mem_word(fin), -1, 32'd0, -1, 32'd0);
        end
    endtask

    initial begin
        rst               = 1'b1;
        pc_next           = 32'd0;
        mem_if.mem_rdata  = 32'd0;
        drive_idle();
        model_pc          = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (5) tick();
        check32("rst_pc", pc, 32'd0);
        check32("rst_instr_raw", instr_raw, NOP);
        check32("rst_instr_pc", instr_pc, 32'd0);
        check32("rst_mem_req", {31'd0, mem_if.mem_req}, 32'd0);
        check32("rst_mem_addr", mem_if.mem_addr, 32'd0);
        check32("rst_busy", {31'd0, busy}, 32'd0);
        check32("rst_fetch_done", {31'd0, fetch_done}, 32'd0);
`ifdef FETCHER_MISALIGN_EN
        check32("rst_fetch_err", {31'd0, fetch_err}, 32'd0);
`endif

        // minimum latency fetch at reset pc
        run_fetch(32'd0, 0, 0, 32'd0, 32'd0, 0, 0);
        // grant held off three cycles at 0x40
        run_fetch(32'h40, 1, 0, 32'd0, 32'd0, 3, 1);
        // redirect to 0x80 while waiting for data
        run_fetch(32'h20, 1, 2, 32'h80, 32'd0, -1, -1);
        // same-cycle pc_we and fetch_start, and redirect with rvalid
        run_fetch(32'h100, 2, 3, 32'h104, 32'd0, 1, 2);

        // reset while in WAIT
        redirect(32'h300);
        fetch_start = 1'b1;
        exp_req.push_back(32'h300);
        tick();
        drive_idle();
        mem_if.mem_gnt = 1'b1;
        tick();
        drive_idle();
        #2 rst = 1'b1;
        #1;
        check32("wrst_pc", pc, 32'd0);
        check32("wrst_instr_raw", instr_raw, NOP);
        check32("wrst_instr_pc", instr_pc, 32'd0);
        check32("wrst_mem_req", {31'd0, mem_if.mem_req}, 32'd0);
        check32("wrst_mem_addr", mem_if.mem_addr, 32'd0);
        check32("wrst_busy", {31'd0, busy}, 32'd0);
        check32("wrst_fetch_done", {31'd0, fetch_done}, 32'd0);
        tick();
        rst = 1'b0;
        model_pc = 32'd0;
        mem_if.mem_rvalid = 1'b1;
        mem_if.mem_rdata  = 32'h1234_5678;
        tick();
        drive_idle();
        check32("late_rvalid_done", {31'd0, fetch_done}, 32'd0);
        check32("late_rvalid_raw", instr_raw, NOP);
        check32("late_rvalid_busy", {31'd0, busy}, 32'd0);

        // misaligned pc
`ifdef FETCHER_MISALIGN_EN
        redirect(32'h6);
        fetch_start = 1'b1;
        push_done(32'h6, NOP, 32'h6, 1'b1);
        tick();
        drive_idle();
        tick();
        check32("err_held", {31'd0, fetch_err}, 32'd1);
        redirect(32'h200);
        tick();
        drive_idle();
        check32("err_cleared_by_pc_we", {31'd0, fetch_err}, 32'd0);
        run_fetch(32'h7, 2, 0, 32'd0, 32'd0, -1, -1);
        exp_done.delete();
        exp_req.delete();
`else
        run_fetch(32'h6, 2, 0, 32'd0, 32'd0, -1, -1);
`endif
        run_fetch(32'h204, 1, 0, 32'd0, 32'd0, -1, -1);

        // randomized traffic
        for (int n = 0; n < 60; n++) begin
            run_fetch(rand_addr(), int'($urandom_range(0, 2)), int'($urandom_range(0, 4)),
                      rand_addr(), rand_addr(), -1, -1);
            if ($urandom_range(0, 2) == 0) begin
                redirect(rand_addr());
                tick();
                drive_idle();
            end
            repeat ($urandom_range(0, 2)) tick();
        end

        repeat (4) tick();
        check32("req_queue_empty", exp_req.size(), 32'd0);
        check32("done_queue_empty", exp_done.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
